sam_pool: RTL
=============

SAM_POOL -- requirements
Module: sam_pool

Interface
REQ-001 SHALL have parameter POOL_SIZE, default 4, number of consecutive valid samples reduced to one output (legal 2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, sample width in bits, matching the upstream SAM_Con output.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Rst  input  1  synchronous, active-high reset.
REQ-005 Data_In  input  DATA_WIDTH  signed two's-complement sample from SAM_Con Data_Out.
REQ-006 Valid_In  input  1  Data_In qualifier; a sample is consumed on each rising edge where Valid_In=1.
REQ-007 Last_Data_In  input  1  end of stream, from SAM_Con Last_Data_Out; meaningful only when Valid_In=1.
REQ-008 Data_Out  output  DATA_WIDTH  pooled result, registered.
REQ-009 Valid_Out  output  1  single-cycle pulse qualifying Data_Out.
REQ-010 Last_Data_Out  output  1  asserted with the Valid_Out pulse that carries the final result of a stream.

Function
REQ-011 SHALL compute the signed maximum of each non-overlapping window of POOL_SIZE consecutive valid samples (stride = POOL_SIZE).
REQ-012 SHALL hold a window counter cnt (0..POOL_SIZE-1) and a running-max register acc; states: EMPTY (cnt=0), FILLING (cnt>0).
REQ-013 On a valid sample in EMPTY: acc <= Data_In, cnt <= 1; Data_In is not compared with stale acc.
REQ-014 On a valid sample in FILLING: acc <= max(acc, Data_In) under signed comparison; cnt <= cnt+1.
REQ-015 When a valid sample completes the window (cnt=POOL_SIZE-1): next cycle Data_Out = max(acc, Data_In), Valid_Out=1, cnt wraps to 0.
REQ-016 Latency SHALL be exactly one cycle from the completing Valid_In edge to Valid_Out.
REQ-017 Cycles with Valid_In=0 SHALL leave cnt and acc unchanged; gaps of any length are allowed mid-window.
REQ-018 Last_Data_In=1 with Valid_In=1 SHALL flush: the partial window, including the current sample, is emitted next cycle with Valid_Out=1 and Last_Data_Out=1, and cnt returns to 0.
REQ-019 If Last_Data_In coincides with a full window, exactly one output SHALL be produced, with Last_Data_Out=1.
REQ-020 Last_Data_In with Valid_In=0 SHALL be ignored.
REQ-021 Valid_Out and Last_Data_Out SHALL be low in every cycle not carrying a result; Data_Out SHALL hold its last value between pulses.
REQ-022 No backpressure; the consumer SHALL accept every Valid_Out pulse; back-to-back outputs are possible only when POOL_SIZE inputs arrive.
REQ-023 Comparison SHALL be full DATA_WIDTH signed, with no truncation; 0x80000000 is the smallest value.

Reset
REQ-024 Rst=1 at a rising edge SHALL set cnt=0, acc=0, Data_Out=0, Valid_Out=0, Last_Data_Out=0.
REQ-025 Reset mid-window SHALL discard the partial window with no output; the first valid sample after reset starts a new window.
REQ-026 Inputs sampled while Rst=1 SHALL be ignored.

Configuration
REQ-027 Macro SAM_POOL_RELU_EN: when defined, Data_Out SHALL be clamped to 0 when the window maximum is negative (ReLU fused at the output register); all timing is unchanged.
REQ-028 When SAM_POOL_RELU_EN is undefined, Data_Out SHALL be the raw signed maximum, including negative values.

Verification
REQ-029 POOL_SIZE=4, inputs 3,7,-2,5 consecutive -> one cycle after the 4th: Data_Out=7, Valid_Out=1, Last_Data_Out=0.
REQ-030 Inputs 0..15 contiguous, Last on 15 (SAM_Con bench pattern) -> four pulses 3,7,11,15; only the 15 pulse has Last_Data_Out=1.
REQ-031 Inputs -9,-4,-20 with Last on -20 -> one pulse Data_Out=-4 and Last=1 without SAM_POOL_RELU_EN; Data_Out=0 with it.
REQ-032 Inputs 1,_,_,8,_,2,4 (_ = Valid_In low) -> single pulse Data_Out=8 after the 4; window count unaffected by gaps.
REQ-033 Inputs 5,6, then Rst for one cycle, then 1,1,1,1 -> no output for 5,6; one pulse Data_Out=1.
REQ-034 Inputs 0x80000000 x4 -> Data_Out=0x80000000 (RELU off); Last_Data_In high with Valid_In low -> no output.

Source files
------------

// File: rtl/sam_pool.sv
// sam_pool: signed max-pooling over non-overlapping windows of POOL_SIZE valid samples.
// Define SAM_POOL_RELU_EN to clamp negative window maxima to zero at the output register.
module sam_pool #(
    parameter int POOL_SIZE  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] Data_In,
    input  logic                  Valid_In,
    input  logic                  Last_Data_In,
    output logic [DATA_WIDTH-1:0] Data_Out,
    output logic                  Valid_Out,
    output logic                  Last_Data_Out,
    output logic                  Dbg_State
);

    // Handshake: a sample is taken on every rising edge with Valid_In=1 (no ready);
    // Valid_Out is a one-cycle pulse that the consumer must always accept.

    typedef enum logic {
        EMPTY   = 1'b0,
        FILLING = 1'b1
    } state_t;

    localparam int CNT_W = (POOL_SIZE > 2) ? $clog2(POOL_SIZE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POOL_SIZE - 1);

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] acc_nxt;
    logic [DATA_WIDTH-1:0] cand;
    logic [DATA_WIDTH-1:0] result;
    logic                  done;

    // State register: window bookkeeping plus the registered output stage.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state         <= EMPTY;
            cnt           <= '0;
            acc           <= '0;
            Data_Out      <= '0;
            Valid_Out     <= 1'b0;
            Last_Data_Out <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            acc           <= acc_nxt;
            Valid_Out     <= done;
            Last_Data_Out <= done && Last_Data_In;
            if (done) begin
                Data_Out <= result;
            end
        end
    end

    // Next-state logic. A sample opening a window never sees the stale accumulator.
    always_comb begin
        cand = Data_In;
        if (state == FILLING && $signed(acc) > $signed(Data_In)) begin
            cand = acc;
        end
        done      = Valid_In && (Last_Data_In || cnt == CNT_LAST);
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        if (Valid_In) begin
            acc_nxt = cand;
            if (done) begin
                cnt_nxt   = '0;
                state_nxt = EMPTY;
            end else begin
                cnt_nxt   = cnt + 1'b1;
                state_nxt = FILLING;
            end
        end
    end

    // Output logic: value loaded into Data_Out when a window closes.
    always_comb begin
        result    = cand;
`ifdef SAM_POOL_RELU_EN
        if (cand[DATA_WIDTH-1]) begin
            result = '0;
        end
`endif
        Dbg_State = state;
    end

endmodule
